// File: rtl/apx_metric_pkg.sv
// rtl/apx_metric_pkg.sv - shared defaults, width helpers and FSM states for apx_err_metric
package apx_metric_pkg;

  localparam int FRAC_DEF   = 12;  // fractional bits of relative error
  localparam int LOG2_N_DEF = 8;   // log2 of samples per sweep

  // Quotient width: 8 integer bits cover the largest ED/exact ratio (254).
  function automatic int qw_f(input int frac);
    return 8 + frac;
  endfunction

  // Relative-error accumulator width: N worst-case quotients never wrap.
  function automatic int red_acc_w(input int frac, input int log2_n);
    return 8 + frac + log2_n;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/apx_serial_div.sv
// rtl/apx_serial_div.sv - restoring divider, one quotient bit per cycle, QW cycles per divide
// Ports: clk, rst_n (async active-low), start (load operands), abort (drop current divide),
//        dividend[QW], divisor[8], busy, done (high in the last iteration cycle), quotient[QW].
module apx_serial_div
  import apx_metric_pkg::*;
#(
  parameter int QW = qw_f(FRAC_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [QW-1:0] dividend,
  input  logic [7:0]    divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CNTW = $clog2(QW);

  logic            busy_q, busy_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [7:0]      rem_q, rem_d;
  logic [7:0]      dsr_q, dsr_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [QW-1:0]   shf_q, shf_d;
  logic [8:0]      trial;

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNTW'(QW - 1));
  assign quotient = shf_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    shf_d  = shf_q;
    trial  = {rem_q, shf_q[QW-1]};
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      dsr_d  = divisor;
      shf_d  = dividend;
    end else if (busy_q) begin
      if (trial >= {1'b0, dsr_q}) begin
        rem_d = 8'(trial - {1'b0, dsr_q});
        shf_d = {shf_q[QW-2:0], 1'b1};
      end else begin
        rem_d = trial[7:0];
        shf_d = {shf_q[QW-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNTW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      shf_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      shf_q  <= shf_d;
    end
  end

endmodule

// File: rtl/apx_err_metric.sv
// rtl/apx_err_metric.sv - error-metric stage for the 4x4 approximate multiplier (ED, RED, counts)
// Ports: clk, rst_n (async active-low), clear (sync sweep restart), in_valid/in_ready handshake,
//        in_a[4], in_b[4], in_approx[8]; done, mean_red[QW], sum_ed[8+LOG2_N],
//        err_count[LOG2_N+1], max_ed[8], max_ab[8].
// Macro APX_ERR_MAX_EN enables max_ed/max_ab tracking; otherwise both are tied to 0.
module apx_err_metric
  import apx_metric_pkg::*;
#(
  parameter int FRAC   = FRAC_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_a,
  input  logic [3:0]        in_b,
  input  logic [7:0]        in_approx,
  output logic              done,
  output logic [7+FRAC:0]   mean_red,
  output logic [7+LOG2_N:0] sum_ed,
  output logic [LOG2_N:0]   err_count,
  output logic [7:0]        max_ed,
  output logic [7:0]        max_ab
);

  localparam int QW = qw_f(FRAC);
  localparam int RW = red_acc_w(FRAC, LOG2_N);
  localparam int EW = 8 + LOG2_N;
  localparam int CW = LOG2_N + 1;
  localparam logic [CW-1:0] N_SAMPLES = CW'(2 ** LOG2_N);

  state_e        state_q, state_d;
  logic          post_acc_q, post_acc_d;
  logic [7:0]    ed_q, ed_d;
  logic          use_div_q, use_div_d;
  logic [RW-1:0] sum_red_q, sum_red_d;
  logic [EW-1:0] ed_acc_q, ed_acc_d;
  logic [CW-1:0] err_acc_q, err_acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] mean_red_q, mean_red_d;
  logic [EW-1:0] sum_ed_q, sum_ed_d;
  logic [CW-1:0] err_count_q, err_count_d;

  logic          accept, div_start, div_busy, div_done;
  logic [7:0]    exact_in, ed_in;
  logic [QW-1:0] div_q;

  assign exact_in  = {4'b0, in_a} * {4'b0, in_b};
  assign ed_in     = (in_approx >= exact_in) ? (in_approx - exact_in) : (exact_in - in_approx);
  // A sample stays "in flight" through the cycle its results reach the outputs.
  assign in_ready  = (state_q == IDLE) && !post_acc_q;
  assign accept    = in_valid && in_ready && !clear;
  assign div_start = accept && (ed_in != 8'd0) && (exact_in != 8'd0);
  assign done      = (state_q == DONE);
  assign mean_red  = mean_red_q;
  assign sum_ed    = sum_ed_q;
  assign err_count = err_count_q;

  apx_serial_div #(.QW(QW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (clear),
    .dividend ({ed_in, {FRAC{1'b0}}}),
    .divisor  (exact_in),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_d     = state_q;
    post_acc_d  = 1'b0;
    ed_d        = ed_q;
    use_div_d   = use_div_q;
    sum_red_d   = sum_red_q;
    ed_acc_d    = ed_acc_q;
    err_acc_d   = err_acc_q;
    cnt_d       = cnt_q;
    mean_red_d  = QW'(sum_red_q >> LOG2_N);
    sum_ed_d    = ed_acc_q;
    err_count_d = err_acc_q;
    if (clear) begin
      state_d     = IDLE;
      ed_d        = '0;
      use_div_d   = 1'b0;
      sum_red_d   = '0;
      ed_acc_d    = '0;
      err_acc_d   = '0;
      cnt_d       = '0;
      mean_red_d  = '0;
      sum_ed_d    = '0;
      err_count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ed_d      = ed_in;
            use_div_d = div_start;
            state_d   = div_start ? DIV : ACC;
          end
        end
        DIV: begin
          // !div_busy guards against ever stalling here if the divider stopped early.
          if (div_done || !div_busy) state_d = ACC;
        end
        ACC: begin
          sum_red_d  = sum_red_q + (use_div_q ? RW'(div_q) : RW'(0));
          ed_acc_d   = ed_acc_q + EW'(ed_q);
          err_acc_d  = err_acc_q + CW'(ed_q != 8'd0);
          cnt_d      = cnt_q + CW'(1);
          post_acc_d = 1'b1;
          state_d    = ((cnt_q + CW'(1)) == N_SAMPLES) ? DONE : IDLE;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      post_acc_q  <= 1'b0;
      ed_q        <= '0;
      use_div_q   <= 1'b0;
      sum_red_q   <= '0;
      ed_acc_q    <= '0;
      err_acc_q   <= '0;
      cnt_q       <= '0;
      mean_red_q  <= '0;
      sum_ed_q    <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      post_acc_q  <= post_acc_d;
      ed_q        <= ed_d;
      use_div_q   <= use_div_d;
      sum_red_q   <= sum_red_d;
      ed_acc_q    <= ed_acc_d;
      err_acc_q   <= err_acc_d;
      cnt_q       <= cnt_d;
      mean_red_q  <= mean_red_d;
      sum_ed_q    <= sum_ed_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef APX_ERR_MAX_EN
  logic [7:0] ab_q, ab_d, max_ed_q, max_ed_d, max_ab_q, max_ab_d;

  always_comb begin
    ab_d     = ab_q;
    max_ed_d = max_ed_q;
    max_ab_d = max_ab_q;
    if (clear) begin
      ab_d     = '0;
      max_ed_d = '0;
      max_ab_d = '0;
    end else begin
      if (accept) ab_d = {in_a, in_b};
      // Strictly greater keeps the first sample that reached the maximum.
      if ((state_q == ACC) && (ed_q > max_ed_q)) begin
        max_ed_d = ed_q;
        max_ab_d = ab_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q     <= '0;
      max_ed_q <= '0;
      max_ab_q <= '0;
    end else begin
      ab_q     <= ab_d;
      max_ed_q <= max_ed_d;
      max_ab_q <= max_ab_d;
    end
  end

  assign max_ed = max_ed_q;
  assign max_ab = max_ab_q;
`else
  assign max_ed = 8'd0;
  assign max_ab = 8'd0;
`endif

endmodule

// File: tb/tb_apx_err_metric.sv
// tb/tb_apx_err_metric.sv - self-checking bench for apx_err_metric (honours APX_ERR_MAX_EN)
module tb_apx_err_metric;

`ifdef APX_ERR_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic        in_ready, done;
  logic [3:0]  in_a = '0, in_b = '0;
  logic [7:0]  in_approx = '0;
  logic [19:0] mean_red;
  logic [15:0] sum_ed;
  logic [8:0]  err_count;
  logic [7:0]  max_ed, max_ab;

  int n_cmp = 0;
  int n_bad = 0;

  longint     m_sum_red;
  int         m_sum_ed, m_err, m_max_ed;
  logic [7:0] m_max_ab;

  apx_err_metric dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .done(done), .mean_red(mean_red),
    .sum_ed(sum_ed), .err_count(err_count), .max_ed(max_ed), .max_ab(max_ab)
  );

  always #5 clk = ~clk;

  function automatic int ref_ed(input int a, input int b, input int ap);
    return (ap >= a * b) ? ap - a * b : a * b - ap;
  endfunction

  function automatic int ref_red(input int a, input int b, input int ap);
    int d;
    d = ref_ed(a, b, ap);
    if (d == 0 || a * b == 0) return 0;
    return (d * 4096) / (a * b);
  endfunction

  task automatic model_reset();
    m_sum_red = 0; m_sum_ed = 0; m_err = 0; m_max_ed = 0; m_max_ab = 8'h00;
  endtask

  task automatic model_add(input int a, input int b, input int ap);
    int d;
    d = ref_ed(a, b, ap);
    m_sum_red += longint'(ref_red(a, b, ap));
    m_sum_ed  += d;
    if (d != 0) m_err++;
    if (d > m_max_ed) begin m_max_ed = d; m_max_ab = {4'(a), 4'(b)}; end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_reset();
  endtask

  // Offers one sample; lat = cycles in_ready stays low after the accepting edge.
  task automatic push(input int a, input int b, input int ap, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    in_a = 4'(a); in_b = 4'(b); in_approx = 8'(ap); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!in_ready && !done && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b exp 0", done); end
    n_cmp++; if (mean_red !== 20'd0) begin n_bad++; $display("FAIL reset_mean got %0d exp 0", mean_red); end
    n_cmp++; if (sum_ed !== 16'd0) begin n_bad++; $display("FAIL reset_sum_ed got %0d exp 0", sum_ed); end
    n_cmp++; if (err_count !== 9'd0) begin n_bad++; $display("FAIL reset_err got %0d exp 0", err_count); end
    n_cmp++; if ({max_ed, max_ab} !== 16'd0) begin n_bad++; $display("FAIL reset_max got %h exp 0", {max_ed, max_ab}); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_zero_exact();
    int lat;
    do_clear();
    push(0, 7, 4, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL zero_lat got %0d exp 2", lat); end
    n_cmp++; if (sum_ed !== 16'd4) begin n_bad++; $display("FAIL zero_sum_ed got %0d exp 4", sum_ed); end
    n_cmp++; if (err_count !== 9'd1) begin n_bad++; $display("FAIL zero_err got %0d exp 1", err_count); end
    n_cmp++; if (mean_red !== 20'd0) begin n_bad++; $display("FAIL zero_mean got %0d exp 0", mean_red); end
    n_cmp++; if (max_ed !== (MAX_EN ? 8'd4 : 8'd0)) begin n_bad++; $display("FAIL zero_max_ed got %0d exp %0d", max_ed, MAX_EN ? 4 : 0); end
    n_cmp++; if (max_ab !== (MAX_EN ? 8'h07 : 8'h00)) begin n_bad++; $display("FAIL zero_max_ab got %h exp %h", max_ab, MAX_EN ? 8'h07 : 8'h00); end
  endtask

  // N identical samples make mean_red equal the per-sample quotient.
  task automatic test_const_sweep(input int a, input int b, input int ap, input int exp_q, input int exp_lat);
    int lat, d;
    d = ref_ed(a, b, ap);
    do_clear();
    for (int i = 0; i < 256; i++) begin
      push(a, b, ap, lat);
      if (i == 0) begin
        n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL const_lat a=%0d b=%0d got %0d exp %0d", a, b, lat, exp_lat); end
      end
      if (i == 254) begin
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL const_early_done got %0b exp 0", done); end
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL const_done got %0b exp 1", done); end
    n_cmp++; if (mean_red !== 20'(exp_q)) begin n_bad++; $display("FAIL const_mean a=%0d b=%0d got %0d exp %0d", a, b, mean_red, exp_q); end
    n_cmp++; if (sum_ed !== 16'(256 * d)) begin n_bad++; $display("FAIL const_sum_ed got %0d exp %0d", sum_ed, 256 * d); end
    n_cmp++; if (err_count !== 9'd256) begin n_bad++; $display("FAIL const_err got %0d exp 256", err_count); end
  endtask

  task automatic test_single_error();
    int lat;
    do_clear();
    push(1, 1, 2, lat);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        if (!(a == 1 && b == 1)) push(a, b, a * b, lat);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done got %0b exp 1", done); end
    n_cmp++; if (mean_red !== 20'd16) begin n_bad++; $display("FAIL single_mean got %0d exp 16", mean_red); end
    n_cmp++; if (sum_ed !== 16'd1) begin n_bad++; $display("FAIL single_sum_ed got %0d exp 1", sum_ed); end
    n_cmp++; if (err_count !== 9'd1) begin n_bad++; $display("FAIL single_err got %0d exp 1", err_count); end
    n_cmp++; if (max_ab !== (MAX_EN ? 8'h11 : 8'h00)) begin n_bad++; $display("FAIL single_max_ab got %h exp %h", max_ab, MAX_EN ? 8'h11 : 8'h00); end
  endtask

  task automatic test_exact_sweep();
    int lat;
    do_clear();
    for (int i = 0; i < 256; i++) begin
      push(i / 16, i % 16, (i / 16) * (i % 16), lat);
      if (i == 254) begin
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL exact_early_done got %0b exp 0", done); end
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL exact_done got %0b exp 1", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL exact_ready got %0b exp 0", in_ready); end
    n_cmp++; if ({mean_red, sum_ed, err_count, max_ed} !== 53'd0) begin n_bad++; $display("FAIL exact_totals got mean=%0d ed=%0d err=%0d max=%0d exp all 0", mean_red, sum_ed, err_count, max_ed); end
  endtask

  task automatic test_random_sweep();
    int a, b, ap, lat, exp_lat;
    do_clear();
    for (int i = 0; i < 256; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      ap = ($urandom_range(0, 1) == 0) ? a * b : int'($urandom_range(0, 255));
      exp_lat = (ref_ed(a, b, ap) != 0 && a * b != 0) ? 22 : 2;
      push(a, b, ap, lat);
      model_add(a, b, ap);
      if (i < 255) begin
        n_cmp++;
        if (lat != exp_lat || sum_ed !== 16'(m_sum_ed) || err_count !== 9'(m_err) || mean_red !== 20'(m_sum_red >> 8)) begin
          n_bad++;
          $display("FAIL rand_step%0d a=%0d b=%0d ap=%0d got lat=%0d ed=%0d err=%0d mean=%0d exp lat=%0d ed=%0d err=%0d mean=%0d",
                   i, a, b, ap, lat, sum_ed, err_count, mean_red, exp_lat, m_sum_ed, m_err, m_sum_red >> 8);
        end
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rand_done got %0b exp 1", done); end
    n_cmp++; if (mean_red !== 20'(m_sum_red >> 8)) begin n_bad++; $display("FAIL rand_mean got %0d exp %0d", mean_red, m_sum_red >> 8); end
    n_cmp++; if (sum_ed !== 16'(m_sum_ed)) begin n_bad++; $display("FAIL rand_sum_ed got %0d exp %0d", sum_ed, m_sum_ed); end
    n_cmp++; if (err_count !== 9'(m_err)) begin n_bad++; $display("FAIL rand_err got %0d exp %0d", err_count, m_err); end
    n_cmp++; if (max_ed !== (MAX_EN ? 8'(m_max_ed) : 8'd0)) begin n_bad++; $display("FAIL rand_max_ed got %0d exp %0d", max_ed, MAX_EN ? m_max_ed : 0); end
    n_cmp++; if (max_ab !== (MAX_EN ? m_max_ab : 8'h00)) begin n_bad++; $display("FAIL rand_max_ab got %h exp %h", max_ab, MAX_EN ? m_max_ab : 8'h00); end
  endtask

  task automatic test_backpressure();
    do_clear();
    @(negedge clk);
    in_a = 4'd3; in_b = 4'd5; in_approx = 8'd16; in_valid = 1'b1;
    @(posedge clk);
    repeat (21) @(posedge clk);
    #1; in_valid = 1'b0;
    repeat (30) @(posedge clk); #1;
    n_cmp++; if (sum_ed !== 16'd1) begin n_bad++; $display("FAIL bp_sum_ed got %0d exp 1", sum_ed); end
    n_cmp++; if (err_count !== 9'd1) begin n_bad++; $display("FAIL bp_err got %0d exp 1", err_count); end
    n_cmp++; if (mean_red !== 20'd1) begin n_bad++; $display("FAIL bp_mean got %0d exp 1", mean_red); end
  endtask

  task automatic test_clear_mid_div();
    int lat;
    do_clear();
    push(0, 7, 4, lat);
    @(negedge clk);
    in_a = 4'd3; in_b = 4'd5; in_approx = 8'd16; in_valid = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1; clear = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready got %0b exp 1", in_ready); end
    n_cmp++; if ({sum_ed, err_count, mean_red} !== 45'd0) begin n_bad++; $display("FAIL clr_totals got ed=%0d err=%0d mean=%0d exp 0", sum_ed, err_count, mean_red); end
    n_cmp++; if ({done, max_ed} !== 9'd0) begin n_bad++; $display("FAIL clr_done_max got %h exp 0", {done, max_ed}); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    repeat (30) @(posedge clk); #1;
    n_cmp++; if (sum_ed !== 16'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ignore got ed=%0d ready=%0b exp 0 1", sum_ed, in_ready); end
  endtask

  task automatic test_async_reset();
    int lat;
    do_clear();
    push(0, 7, 4, lat);
    @(negedge clk);
    in_a = 4'd3; in_b = 4'd5; in_approx = 8'd16; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready got %0b exp 1", in_ready); end
    n_cmp++; if ({done, sum_ed, err_count, mean_red} !== 46'd0) begin n_bad++; $display("FAIL arst_totals got done=%0b ed=%0d err=%0d mean=%0d exp 0", done, sum_ed, err_count, mean_red); end
    n_cmp++; if ({max_ed, max_ab} !== 16'd0) begin n_bad++; $display("FAIL arst_max got %h exp 0", {max_ed, max_ab}); end
    @(negedge clk); rst_n = 1'b1;
    push(1, 1, 2, lat);
    n_cmp++; if (lat != 22 || sum_ed !== 16'd1) begin n_bad++; $display("FAIL arst_resume got lat=%0d ed=%0d exp 22 1", lat, sum_ed); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_exact();
    test_const_sweep(3, 5, 16, 273, 22);
    test_const_sweep(15, 15, 0, 4096, 22);
    test_single_error();
    test_exact_sweep();
    test_random_sweep();
    test_backpressure();
    test_clear_mid_div();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apx_err_metric.md
Name: apx_err_metric

Overview:
- Hardware error-metric stage directly downstream of the 4-bit approximate multiplier.
- Per accepted sample, consumes operands A, B and the approximate product.
- Computes the exact product, error distance (ED) and fixed-point relative error (RED) using a serial divider.
- Accumulates over a full sweep of N samples and reports mean RED, sum of ED and erroneous-sample count, replacing the real-valued simulation-only metric with synthesizable hardware.

Parameters:
- FRAC, 12: fractional bits of RED; quotient width QW = 8+FRAC.
- LOG2_N, 8: log2 of samples per sweep; N = 2**LOG2_N (256 covers every 4x4 operand pair).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- clear  in  1  synchronous sweep restart; priority over in_valid
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- in_a  in  4  operand A
- in_b  in  4  operand B
- in_approx  in  8  approximate product
- done  out  1  N samples accumulated; results frozen
- mean_red  out  QW  sum_red >> LOG2_N, unsigned Q8.FRAC
- sum_ed  out  8+LOG2_N  sum of |approx-exact|
- err_count  out  LOG2_N+1  samples with approx != exact
- max_ed  out  8  largest ED (optional feature)
- max_ab  out  8  {A,B} of the first sample reaching max_ed (optional feature)

Behaviour:
- Reset values: in_ready=1, done=0. mean_red, sum_ed, err_count, max_ed, max_ab and all internal accumulators are 0. FSM enters IDLE.
- exact = in_a*in_b (8 bits, unsigned); ED = |in_approx - exact| (8 bits). Both are captured on accept (in_valid && in_ready).
- RED = (ED << FRAC) / exact, truncated, QW bits. Maximum is 254<<FRAC.
- exact==0: RED=0, but the sample still counts toward N and toward ED/err_count.
- ED==0: RED=0 and the divider is skipped.
- FSM states:
  - IDLE: in_ready=1. On accept, go to DIV if ED!=0 && exact!=0, else go to ACC with quotient 0.
  - DIV: in_ready=0. Restoring divide, one quotient bit per cycle, exactly QW cycles, then go to ACC.
  - ACC: in_ready=0, one cycle. sum_red += q; sum_ed += ED; err_count += (ED!=0); sample_cnt += 1. If sample_cnt reaches N, go to DONE, else return to IDLE.
  - DONE: in_ready=0, done=1. All outputs hold until clear.
- Sample latency: 2 cycles when the divider is skipped, QW+2 cycles otherwise.
- Overflow: accumulators are sized for N worst-case samples and never wrap. sum_red is QW+LOG2_N bits.
- Output update timing: mean_red, sum_ed and err_count are registered and update in the cycle after each ACC, so they are live during the sweep.
- clear: from any state (including mid-DIV), zero all accumulators and counters, abort the divider, drop done, and enter IDLE next cycle. in_valid is ignored in that cycle.
- Reset mid-operation: same effect as clear, but asynchronous.
- in_valid while in_ready=0: no effect. The upstream source holds the sample until it is accepted.

Optional Feature:
- Macro: APX_ERR_MAX_EN.
- Defined: tracks max_ed and max_ab, updated in ACC when ED > max_ed (strictly greater, so the first occurrence wins). Cleared by reset/clear.
- Undefined: no tracking logic; max_ed and max_ab are tied to 0.

Decomposition:
- Package apx_metric_pkg holds: FRAC and LOG2_N defaults, QW/accumulator width functions, FSM state enum {IDLE, DIV, ACC, DONE}.
- Sub-module apx_serial_div: restoring divider with start/busy/done, QW-bit dividend, 8-bit divisor, abort input driven by clear.

Test Plan:
- Exact source, all 256 {A,B} combinations -> done after the 256th ACC; mean_red=0, sum_ed=0, err_count=0, max_ed=0.
- A=1,B=1,approx=2, other 255 samples exact -> q=4096, mean_red=16 (0.39%), sum_ed=1, err_count=1.
- A=3,B=5,approx=16 single sample -> q=273 (4096/15 truncated); in_ready low for exactly 22 cycles after accept.
- A=0,B=7,approx=4 -> no divide (ready low 2 cycles), RED=0, sum_ed=4, err_count=1; with APX_ERR_MAX_EN, max_ed=4, max_ab=8'h07.
- A=15,B=15,approx=0 -> ED=225, q=(225<<12)/225=4096.
- Backpressure: in_valid held high across DIV -> exactly one accept; asserting clear in DIV cycle 5 -> IDLE next cycle, accumulators 0.
- Async rst_n low mid-DIV -> all outputs 0 and in_ready=1 immediately, without waiting for a clock edge.
